// File: rtl/sys_reset_status_ctrl.sv
// PLL-lock supervisor: holds the core in reset until lock is stable, drives heartbeat and activity LEDs.
// Optional lock-loss monitor (lock_lost, lock_loss_cnt) is built only when LOCK_LOSS_MON_EN is defined.
//
// state     | meaning
// WAIT_LOCK | core held in reset, waiting for synchronised lock
// STABLE    | lock seen, counting consecutive locked cycles
// RUN       | core released, heartbeat running
module sys_reset_status_ctrl #(
   parameter int unsigned LOCK_STABLE_CYCLES = 1024,
   parameter int unsigned HB_DIV             = 25000000,
   parameter int unsigned N_ACT              = 2,
   parameter int unsigned ACT_STRETCH        = 2500000,
   parameter logic        ACT_IDLE           = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pll_locked,
   input  logic [N_ACT-1:0] act_in,
   output logic             core_rst,
   output logic             ready,
   output logic             heartbeat,
   output logic [N_ACT-1:0] act_led,
   output logic             lock_lost,
   output logic [7:0]       lock_loss_cnt
);

   localparam int unsigned CW = $clog2(LOCK_STABLE_CYCLES + 1);
   localparam int unsigned HW = $clog2(HB_DIV + 1);
   localparam int unsigned AW = $clog2(ACT_STRETCH + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [HW-1:0] HB_LAST  = HW'(HB_DIV - 1);
   localparam logic [AW-1:0] ACT_LOAD = AW'(ACT_STRETCH);

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      STABLE    = 2'd1,
      RUN       = 2'd2
   } state_t;

   state_t           state;
   state_t           next_state;
   logic             lock_meta;
   logic             locked_s;
   logic [CW-1:0]    cnt;
   logic [HW-1:0]    hb_cnt;
   logic [N_ACT-1:0] act_meta;
   logic [N_ACT-1:0] act_sync;
   logic [N_ACT-1:0] act_dly;
   logic [N_ACT-1:0] act_edge;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock_meta <= 1'b0;
         locked_s  <= 1'b0;
      end else begin
         lock_meta <= pll_locked;
         locked_s  <= lock_meta;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= WAIT_LOCK;
         cnt   <= '0;
      end else begin
         state <= next_state;
         if (state == STABLE && next_state == STABLE)
            cnt <= cnt + CW'(1);
         else
            cnt <= '0;
      end
   end

   // A lock drop on the terminal-count cycle must win, so it is tested first.
   always_comb begin
      next_state = state;
      case (state)
         WAIT_LOCK: if (locked_s) next_state = STABLE;
         STABLE: begin
            if (!locked_s)
               next_state = WAIT_LOCK;
            else if (cnt == CNT_LAST)
               next_state = RUN;
         end
         RUN:       if (!locked_s) next_state = WAIT_LOCK;
         default:   next_state = WAIT_LOCK;
      endcase
   end

   always_comb begin
      core_rst = 1'b1;
      ready    = 1'b0;
      if (state == RUN) begin
         core_rst = 1'b0;
         ready    = 1'b1;
      end
   end

   // Counting starts on the first edge spent in RUN; the leaving edge clears.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hb_cnt    <= '0;
         heartbeat <= 1'b0;
      end else if (state == RUN && next_state == RUN) begin
         if (hb_cnt == HB_LAST) begin
            hb_cnt    <= '0;
            heartbeat <= ~heartbeat;
         end else begin
            hb_cnt <= hb_cnt + HW'(1);
         end
      end else begin
         hb_cnt    <= '0;
         heartbeat <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         act_meta <= {N_ACT{ACT_IDLE}};
         act_sync <= {N_ACT{ACT_IDLE}};
         act_dly  <= {N_ACT{ACT_IDLE}};
         act_edge <= '0;
      end else begin
         act_meta <= act_in;
         act_sync <= act_meta;
         act_dly  <= act_sync;
         act_edge <= act_sync ^ act_dly;
      end
   end

   for (genvar i = 0; i < N_ACT; i++) begin : g_act
      logic [AW-1:0] stretch;

      always_ff @(posedge clk or posedge rst) begin
         if (rst)
            stretch <= '0;
         else if (act_edge[i])
            stretch <= ACT_LOAD;
         else if (stretch != '0)
            stretch <= stretch - AW'(1);
      end

      assign act_led[i] = (stretch != '0);
   end

`ifdef LOCK_LOSS_MON_EN
   logic lock_drop;
   assign lock_drop = (state == RUN) && (next_state == WAIT_LOCK);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock_lost     <= 1'b0;
         lock_loss_cnt <= '0;
      end else if (lock_drop) begin
         lock_lost <= 1'b1;
         if (lock_loss_cnt != 8'hFF)
            lock_loss_cnt <= lock_loss_cnt + 8'd1;
      end
   end
`else
   assign lock_lost     = 1'b0;
   assign lock_loss_cnt = '0;
`endif

endmodule

// File: tb/tb_sys_reset_status_ctrl.sv
// Self-checking bench for sys_reset_status_ctrl with small parameters (stable=4, hb=3, stretch=5).
// Lock-loss expectations follow LOCK_LOSS_MON_EN as seen by the bench.
module tb_sys_reset_status_ctrl;

   localparam int L  = 4;
   localparam int HB = 3;
   localparam int S  = 5;

   logic       clk = 1'b0;
   logic       rst;
   logic       pll_locked;
   logic [1:0] act_in;
   logic       core_rst;
   logic       ready;
   logic       heartbeat;
   logic [1:0] act_led;
   logic       lock_lost;
   logic [7:0] lock_loss_cnt;

   typedef struct packed {
      logic       core;
      logic       rdy;
      logic       hb;
      logic [1:0] act;
      logic       lost;
      logic [7:0] lcnt;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   exp_losses = 0;

   sys_reset_status_ctrl #(
      .LOCK_STABLE_CYCLES(L),
      .HB_DIV(HB),
      .N_ACT(2),
      .ACT_STRETCH(S),
      .ACT_IDLE(1'b1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .pll_locked(pll_locked),
      .act_in(act_in),
      .core_rst(core_rst),
      .ready(ready),
      .heartbeat(heartbeat),
      .act_led(act_led),
      .lock_lost(lock_lost),
      .lock_loss_cnt(lock_loss_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      exp_t obs, e;
      rst = 1'b1;
      pll_locked = 1'b0;
      act_in = 2'b11;
      #2;
      obs = {core_rst, ready, heartbeat, act_led, lock_lost, lock_loss_cnt};
      e   = {1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'd0};
      n_tests++;
      if (obs !== e) begin
         n_fail++;
         $display("FAIL reset_values: got %b want %b", obs, e);
      end
      tick();
      tick();
      rst = 1'b0;
      for (int j = 0; j < 3; j++) begin
         sb.push_back({1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'd0});
         tick();
         e   = sb.pop_front();
         obs = {core_rst, ready, heartbeat, act_led, lock_lost, lock_loss_cnt};
         n_tests++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL reset_idle cyc %0d: got %b want %b", j, obs, e);
         end
      end
   endtask

   // Release latency and heartbeat pattern after entering RUN.
   task automatic test_release();
      exp_t obs, e;
      int   en;
      en = L + 2;
      pll_locked = 1'b1;
      for (int j = 0; j <= en + 8; j++) begin
         e = '0;
         e.core = (j < en);
         e.rdy  = (j >= en);
         e.hb   = (j < en) ? 1'b0 : 1'(((j - en) / HB) % 2);
         sb.push_back(e);
      end
      for (int j = 0; j <= en + 8; j++) begin
         tick();
         e = sb.pop_front();
         obs = '0;
         obs.core = core_rst;
         obs.rdy  = ready;
         obs.hb   = heartbeat;
         n_tests++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL release_hb edge %0d: got %b want %b", j, obs, e);
         end
      end
   endtask

   task automatic test_lock_loss();
      exp_t obs, e;
      // First drop: heartbeat is high for two edges, then cleared with the reset.
      pll_locked = 1'b0;
      for (int j = 0; j < 4; j++) begin
         e = '0;
         e.core = (j >= 2);
         e.rdy  = (j < 2);
         e.hb   = (j < 2);
`ifdef LOCK_LOSS_MON_EN
         if (j == 2) exp_losses++;
`endif
         e.lost = (exp_losses > 0);
         e.lcnt = 8'(exp_losses);
         sb.push_back(e);
         tick();
         e = sb.pop_front();
         obs = {core_rst, ready, heartbeat, act_led, lock_lost, lock_loss_cnt};
         obs.act = 2'b00;
         n_tests++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL lock_loss1 edge %0d: got %b want %b", j, obs, e);
         end
      end
      pll_locked = 1'b1;
      for (int j = 0; j <= L + 2; j++) begin
         e = '0;
         e.core = (j < L + 2);
         e.rdy  = (j >= L + 2);
         e.lost = (exp_losses > 0);
         e.lcnt = 8'(exp_losses);
         sb.push_back(e);
         tick();
         e = sb.pop_front();
         obs = {core_rst, ready, 1'b0, 2'b00, lock_lost, lock_loss_cnt};
         n_tests++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL relock edge %0d: got %b want %b", j, obs, e);
         end
      end
      pll_locked = 1'b0;
      for (int j = 0; j < 3; j++) begin
         e = '0;
         e.core = (j >= 2);
         e.rdy  = (j < 2);
`ifdef LOCK_LOSS_MON_EN
         if (j == 2) exp_losses++;
`endif
         e.lost = (exp_losses > 0);
         e.lcnt = 8'(exp_losses);
         sb.push_back(e);
         tick();
         e = sb.pop_front();
         obs = {core_rst, ready, 1'b0, 2'b00, lock_lost, lock_loss_cnt};
         n_tests++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL lock_loss2 edge %0d: got %b want %b", j, obs, e);
         end
      end
   endtask

   // Lock glitch in STABLE restarts the full stable count from the relock.
   task automatic test_glitch();
      exp_t obs, e;
      for (int j = 0; j < 12; j++) begin
         pll_locked = (j != 3);
         e = '0;
         e.core = (j < 10);
         e.rdy  = (j >= 10);
         sb.push_back(e);
         tick();
         e = sb.pop_front();
         obs = '0;
         obs.core = core_rst;
         obs.rdy  = ready;
         n_tests++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL glitch edge %0d: got %b want %b", j, obs, e);
         end
      end
   endtask

   task automatic test_activity();
      exp_t obs, e;
      // One-cycle low pulse: two edges, reload on the second, lit six cycles.
      for (int j = 0; j < 13; j++) begin
         act_in = (j == 0) ? 2'b10 : 2'b11;
         e = '0;
         e.act = {1'b0, 1'((j >= 3) && (j <= 8))};
         sb.push_back(e);
         tick();
         e = sb.pop_front();
         obs = '0;
         obs.act = act_led;
         n_tests++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL act_pulse edge %0d: got %b want %b", j, obs, e);
         end
      end
      // Single edges on channel 1: each lights exactly S cycles.
      for (int j = 0; j < 20; j++) begin
         act_in = (j < 10) ? 2'b01 : 2'b11;
         e = '0;
         e.act = {1'(((j >= 3) && (j < 3 + S)) || ((j >= 13) && (j < 13 + S))), 1'b0};
         sb.push_back(e);
         tick();
         e = sb.pop_front();
         obs = '0;
         obs.act = act_led;
         n_tests++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL act_hold edge %0d: got %b want %b", j, obs, e);
         end
      end
   endtask

   // Second edge lands on the cycle the counter would reach zero: reload wins.
   task automatic test_act_reload();
      exp_t obs, e;
      for (int j = 0; j < 16; j++) begin
         act_in = (j < 5) ? 2'b10 : 2'b11;
         e = '0;
         e.act = {1'b0, 1'((j >= 3) && (j <= 12))};
         sb.push_back(e);
         tick();
         e = sb.pop_front();
         obs = '0;
         obs.act = act_led;
         n_tests++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL act_reload edge %0d: got %b want %b", j, obs, e);
         end
      end
   endtask

   task automatic test_async_reset();
      exp_t obs, e;
      act_in = 2'b01;
      repeat (4) tick();
      obs = '0;
      obs.rdy = ready;
      obs.act = act_led;
      e = '0;
      e.rdy = 1'b1;
      e.act = 2'b10;
      n_tests++;
      if (obs !== e) begin
         n_fail++;
         $display("FAIL pre_reset: got %b want %b", obs, e);
      end
      #3;
      rst = 1'b1;
      #1;
      exp_losses = 0;
      obs = {core_rst, ready, heartbeat, act_led, lock_lost, lock_loss_cnt};
      e   = {1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'd0};
      n_tests++;
      if (obs !== e) begin
         n_fail++;
         $display("FAIL async_reset: got %b want %b", obs, e);
      end
      act_in = 2'b11;
      tick();
      tick();
      rst = 1'b0;
      for (int j = 0; j < L + 4; j++) begin
         e = '0;
         e.core = (j < L + 2);
         e.rdy  = (j >= L + 2);
         e.lcnt = 8'(exp_losses);
         sb.push_back(e);
         tick();
         e = sb.pop_front();
         obs = {core_rst, ready, 1'b0, act_led, lock_lost, lock_loss_cnt};
         n_tests++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL restart edge %0d: got %b want %b", j, obs, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_release();
      test_lock_loss();
      test_glitch();
      test_activity();
      test_act_reload();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sys_reset_status_ctrl.md
# sys_reset_status_ctrl

Parametrised system supervisor between the PLL and the multi-cycle RISC-V core in the board top level. It holds the core in reset until the PLL lock has been continuously stable for a programmable time. It re-enters reset on loss of lock and drives the board status LEDs: a run-gated heartbeat plus N pulse-stretched activity LEDs, for example UART rx/tx.

## Interface
- LOCK_STABLE_CYCLES, 1024: consecutive synchronised-lock cycles required before releasing the core; ≥1.
- HB_DIV, 25000000: heartbeat half-period in clk cycles; ≥1.
- N_ACT, 2: number of activity channels; ≥1.
- ACT_STRETCH, 2500000: activity LED on-time in clk cycles; ≥1.
- ACT_IDLE, 1'b1: idle level of every act_in bit; also the reset value of its synchroniser.
- clk  in  1  system clock from PLL outclk_0.
- rst  in  1  reset, asynchronous, active-high; clears all state.
- pll_locked  in  1  PLL locked flag, asynchronous to clk.
- act_in  in  N_ACT  activity sources, asynchronous.
- core_rst  out  1  active-high reset to core; asserts asynchronously with rst; deasserts synchronously.
- ready  out  1  high exactly while in RUN.
- heartbeat  out  1  heartbeat LED.
- act_led  out  N_ACT  stretched activity LEDs.
- lock_lost  out  1  sticky lock-loss flag.
- lock_loss_cnt  out  8  saturating lock-loss count.

## Operation
- Synchronisers:
  - pll_locked passes through a 2-FF synchroniser (reset value 0) to produce locked_s.
  - Each act_in bit passes through 2 FFs plus a delay FF, all with reset value ACT_IDLE.
- FSM states are WAIT_LOCK (reset state), STABLE and RUN.
  - WAIT_LOCK: when locked_s=1, go to STABLE with cnt=0.
  - STABLE: locked_s=0 → WAIT_LOCK. Otherwise, cnt==LOCK_STABLE_CYCLES-1 → RUN; else cnt++.
  - RUN: locked_s=0 → WAIT_LOCK.
- Decoded outputs: core_rst = (state!=RUN) and ready = (state==RUN), both taken from the state register.
- Heartbeat:
  - Active in RUN only. hb_cnt counts 0..HB_DIV-1; on wrap, heartbeat toggles.
  - Leaving RUN clears hb_cnt and heartbeat to 0.
- Activity, per channel:
  - Any edge of the synchronised bit loads stretch counter with ACT_STRETCH; otherwise a nonzero counter decrements.
  - act_led[i] = (counter != 0).
  - A retrigger while lit reloads the counter. Channels run in all FSM states.
- Counter widths are $clog2(param+1). No counter ever wraps past its terminal value.
- Simultaneous events:
  - locked_s falling on the cycle cnt reaches its terminal value → WAIT_LOCK; loss wins.
  - Activity edge on the same cycle as the decrement-to-zero → reload wins.

## Timing
- Reset values:
  - core_rst=1, ready=0, heartbeat=0, act_led=0, lock_lost=0, lock_loss_cnt=0.
  - state=WAIT_LOCK, all counters 0.
- Lock-to-release latency: pll_locked=1 sampled at edge k → core_rst low after edge k+2+LOCK_STABLE_CYCLES.
- Lock-loss latency: pll_locked=0 sampled at edge k in RUN → core_rst high after edge k+2.
- First heartbeat toggle occurs HB_DIV edges after entering RUN.
- Activity latency: act_in transition sampled at edge k → act_led high after edge k+3, held exactly ACT_STRETCH cycles with no retrigger.
- Reset mid-operation: rst asserts core_rst and clears everything asynchronously within the same cycle. Deassertion of rst resumes in WAIT_LOCK.

## Configuration
- LOCK_LOSS_MON_EN defined:
  - Each RUN→WAIT_LOCK transition sets lock_lost (sticky until rst).
  - The same transition increments lock_loss_cnt, saturating at 255.
- LOCK_LOSS_MON_EN undefined: lock_lost and lock_loss_cnt are tied to 0 and no monitor logic is built. FSM behaviour is identical in both builds.

## Test plan
- Release: LOCK_STABLE_CYCLES=4; pll_locked=1 before edge 0 → core_rst=1 through edge 5, 0 and ready=1 after edge 6.
- Glitch: LOCK_STABLE_CYCLES=8; pll_locked drops for 1 cycle at STABLE cnt=5 → FSM returns to WAIT_LOCK; release occurs a full 8 cycles after relock.
- Lock loss (macro on): drop lock twice in RUN → core_rst high 2 edges after each drop, lock_lost=1, lock_loss_cnt=2. Repeat with the macro off → lock_lost and lock_loss_cnt remain 0.
- Heartbeat: HB_DIV=3, in RUN → heartbeat toggles every 3 cycles (pattern 0,0,0,1,1,1…). On lock loss it drops to 0.
- Activity: ACT_STRETCH=5, ACT_IDLE=1, 1-cycle low pulse on act_in[0]:
  - act_led[0] goes high 3 edges later.
  - Pulse has two edges → reload on the second edge; led is high for 6 cycles total.
  - act_led[1] stays 0.
- Async reset: assert rst mid-RUN between edges → core_rst=1, heartbeat=0, act_led=0 before the next edge. After release, the FSM restarts from WAIT_LOCK.
